// File: rtl/fetch_queue_if.sv
// Bundles the fetch front end's branch, stall, instruction-memory and IR1 signals.
// master: the fetch queue itself; slave: the pipeline/memory side driving it.
// Signals: redirect/redirect_pc/stall in, imem_addr/imem_en out, imem_q in,
//          ir_out/pc_out/ir_valid/level/squash_count out.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          redirect;
    logic [7:0]    redirect_pc;
    logic          stall;
    logic [7:0]    imem_addr;
    logic          imem_en;
    logic [7:0]    imem_q;
    logic [7:0]    ir_out;
    logic [7:0]    pc_out;
    logic          ir_valid;
    logic [LW-1:0] level;
    logic [7:0]    squash_count;

    modport master (
        input  redirect, redirect_pc, stall, imem_q,
        output imem_addr, imem_en, ir_out, pc_out, ir_valid, level, squash_count
    );

    modport slave (
        output redirect, redirect_pc, stall, imem_q,
        input  imem_addr, imem_en, ir_out, pc_out, ir_valid, level, squash_count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues PCs to imem, queues {instr, pc}, feeds IR1 (NOP when empty).
// Latency: issue -> data next cycle -> head of queue the cycle after (redirect to ir_valid = 2 cycles).
// Backpressure: stall holds the head; fetch stops once queued + in-flight words reach DEPTH.
// Ports: clock, reset (sync, active-high), bus (fetch_queue_if.master): redirect/redirect_pc/stall
//        in, imem_addr/imem_en out, imem_q in, ir_out/pc_out/ir_valid/level/squash_count out.
module fetch_queue #(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] NOP      = 8'b00001010,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic          clock,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    ir_mem [DEPTH];
    logic [7:0]    pc_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [LW-1:0] count;
    logic [7:0]    fetch_pc;
    logic          inflight;
    logic [7:0]    inflight_pc;
    logic [7:0]    squash_count;

    logic          issue;
    logic          push;
    logic          pop;
    logic          head_vld;
    logic [LW:0]   credit_used;
    logic [9:0]    squash_sum;

    // Credits count queued words plus the word still coming back from memory,
    // so a push can never land on a full queue.
    assign credit_used = {1'b0, count} + (LW+1)'(inflight);
    assign issue       = !reset && (bus.redirect || (credit_used < (LW+1)'(DEPTH)));
    assign head_vld    = (count != '0);
    // A redirect squashes the word returning this cycle and freezes the head.
    assign push        = inflight && !bus.redirect;
    assign pop         = head_vld && !bus.stall && !bus.redirect;

    assign squash_sum  = {2'b00, squash_count} + 10'(count) + 10'(inflight);

    assign bus.imem_en      = issue;
    assign bus.imem_addr    = bus.redirect ? bus.redirect_pc : fetch_pc;
    assign bus.ir_valid     = head_vld;
    assign bus.ir_out       = head_vld ? ir_mem[rd_ptr] : NOP;
    assign bus.pc_out       = head_vld ? pc_mem[rd_ptr] : 8'h00;
    assign bus.level        = count;
    assign bus.squash_count = squash_count;

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            ir_mem[wr_ptr] <= bus.imem_q;
            pc_mem[wr_ptr] <= inflight_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            fetch_pc     <= RESET_PC;
            inflight     <= 1'b0;
            inflight_pc  <= RESET_PC;
            squash_count <= 8'h00;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= bus.imem_addr;
                fetch_pc    <= bus.imem_addr + 8'd1;
            end
            if (bus.redirect) begin
                rd_ptr       <= '0;
                wr_ptr       <= '0;
                count        <= '0;
                squash_count <= (squash_sum > 10'd255) ? 8'hFF : squash_sum[7:0];
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + LW'(1);
                    2'b01:   count <= count - LW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && (count == LW'(DEPTH))));

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    localparam int         DEPTH    = 4;
    localparam logic [7:0] NOP      = 8'b00001010;
    localparam logic [7:0] RESET_PC = 8'h00;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fetch_queue_if #(.DEPTH(DEPTH)) bus();

    fetch_queue #(.DEPTH(DEPTH), .NOP(NOP), .RESET_PC(RESET_PC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Instruction memory: address sampled at the edge, word held the following cycle.
    logic [7:0] mem [256];
    always @(posedge clock) bus.imem_q <= mem[bus.imem_addr];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural reference: a queue of fetched words, one optional word in flight.
    typedef struct {
        logic [7:0] ir;
        logic [7:0] pc;
    } ent_t;

    ent_t       mq[$];
    bit         m_infl;
    logic [7:0] m_ipc;
    logic [7:0] m_fpc;
    int         m_sq;
    bit         model_on = 1'b0;
    bit         m_en;
    logic [7:0] m_addr;

    always @(negedge clock) begin
        if (model_on) begin
            m_en   = !reset && (bus.redirect || (mq.size() + int'(m_infl) < DEPTH));
            m_addr = bus.redirect ? bus.redirect_pc : m_fpc;
            check("m_imem_en",   bus.imem_en, m_en);
            check("m_imem_addr", bus.imem_addr, m_addr);
            check("m_level",     bus.level, mq.size());
            check("m_ir_valid",  bus.ir_valid, mq.size() > 0);
            check("m_ir_out",    bus.ir_out, (mq.size() > 0) ? mq[0].ir : NOP);
            check("m_pc_out",    bus.pc_out, (mq.size() > 0) ? mq[0].pc : 8'h00);
            check("m_squash",    bus.squash_count, m_sq);
        end
        if (reset) begin
            mq.delete();
            m_infl   = 1'b0;
            m_fpc    = RESET_PC;
            m_sq     = 0;
            model_on = 1'b1;
        end else if (model_on) begin
            if (bus.redirect) begin
                m_sq = m_sq + mq.size() + int'(m_infl);
                if (m_sq > 255) m_sq = 255;
                mq.delete();
                m_infl = 1'b1;
                m_ipc  = bus.redirect_pc;
                m_fpc  = bus.redirect_pc + 8'd1;
            end else begin
                if (mq.size() > 0 && !bus.stall) void'(mq.pop_front());
                if (m_infl) mq.push_back('{ir: mem[m_ipc], pc: m_ipc});
                if (m_en) begin
                    m_infl = 1'b1;
                    m_ipc  = m_fpc;
                    m_fpc  = m_fpc + 8'd1;
                end else begin
                    m_infl = 1'b0;
                end
            end
        end
    end

    task automatic drive(input bit rs, input bit rd, input logic [7:0] rpc, input bit st);
        reset           = rs;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.stall       = st;
        #1;
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pc_e;
        for (int i = 0; i < 256; i++) mem[i] = 8'(8'h10 + i);

        drive(1, 0, 8'h00, 0);
        repeat (3) next();

        // Cycle 0: reset state, first fetch of RESET_PC.
        drive(0, 0, 8'h00, 0);
        check("rst_level",    bus.level, 0);
        check("rst_ir_out",   bus.ir_out, NOP);
        check("rst_ir_valid", bus.ir_valid, 0);
        check("rst_pc_out",   bus.pc_out, 0);
        check("rst_squash",   bus.squash_count, 0);
        check("rst_en",       bus.imem_en, 1);
        check("rst_addr",     bus.imem_addr, RESET_PC);
        next(); drive(0, 0, 8'h00, 0);
        check("c1_valid", bus.ir_valid, 0);

        // Cycle 2: first instruction; stall begins here for 10 cycles.
        next(); drive(0, 0, 8'h00, 1);
        check("c2_valid", bus.ir_valid, 1);
        check("c2_ir",    bus.ir_out, 8'h10);
        check("c2_pc",    bus.pc_out, 8'h00);
        repeat (9) begin
            next(); drive(0, 0, 8'h00, 1);
            check("stall_hold_ir", bus.ir_out, 8'h10);
        end
        check("stall_level", bus.level, 4);
        check("stall_en",    bus.imem_en, 0);

        // Release: words 0x10.. in order with no gap across the refill.
        for (int k = 0; k < 6; k++) begin
            next(); drive(0, 0, 8'h00, 0);
            check("release_valid", bus.ir_valid, 1);
            check("release_ir",    bus.ir_out, 8'(8'h10 + k));
            check("release_pc",    bus.pc_out, k);
        end

        // Fill under stall, then redirect to 0x40 while still stalled.
        repeat (8) begin next(); drive(0, 0, 8'h00, 1); end
        check("fill_level", bus.level, 4);
        next(); drive(0, 1, 8'h40, 1);
        check("redir_en",   bus.imem_en, 1);
        check("redir_addr", bus.imem_addr, 8'h40);
        next(); drive(0, 0, 8'h00, 0);
        check("redir_level",  bus.level, 0);
        check("redir_valid",  bus.ir_valid, 0);
        check("redir_ir",     bus.ir_out, NOP);
        check("redir_squash", bus.squash_count, 4);
        next(); drive(0, 0, 8'h00, 0);
        check("redir_r2_valid", bus.ir_valid, 1);
        check("redir_r2_pc",    bus.pc_out, 8'h40);
        check("redir_r2_ir",    bus.ir_out, 8'h50);

        // Steady-state redirect to 0xFE: address wraps, level+inflight (2) squashed.
        repeat (3) begin next(); drive(0, 0, 8'h00, 0); end
        check("steady_level", bus.level, 1);
        next(); drive(0, 1, 8'hFE, 0);
        next(); drive(0, 0, 8'h00, 0);
        check("wrap_squash", bus.squash_count, 6);
        check("wrap_r1_valid", bus.ir_valid, 0);
        for (int k = 0; k < 4; k++) begin
            next(); drive(0, 0, 8'h00, 0);
            pc_e = 8'(8'hFE + k);
            check("wrap_pc", bus.pc_out, pc_e);
            check("wrap_ir", bus.ir_out, 8'(pc_e + 8'h10));
        end

        // Back-to-back redirects: steady state squashes 2, then the 0x20 fetch squashes 1.
        next(); drive(0, 1, 8'h20, 0);
        next(); drive(0, 1, 8'h30, 0);
        check("dbl_squash1", bus.squash_count, 8);
        next(); drive(0, 0, 8'h00, 0);
        check("dbl_squash2", bus.squash_count, 9);
        check("dbl_valid0",  bus.ir_valid, 0);
        next(); drive(0, 0, 8'h00, 0);
        check("dbl_valid", bus.ir_valid, 1);
        check("dbl_pc",    bus.pc_out, 8'h30);
        check("dbl_ir",    bus.ir_out, 8'h40);

        // Mid-stream reset with three entries queued.
        repeat (3) begin next(); drive(0, 0, 8'h00, 1); end
        check("mid_level3", bus.level, 3);
        next(); drive(1, 0, 8'h00, 0);
        check("mid_rst_en", bus.imem_en, 0);
        next(); drive(0, 0, 8'h00, 0);
        check("mid_level",  bus.level, 0);
        check("mid_ir",     bus.ir_out, NOP);
        check("mid_squash", bus.squash_count, 0);
        check("mid_addr",   bus.imem_addr, RESET_PC);
        check("mid_en",     bus.imem_en, 1);

        // Over 300 squashes: every back-to-back redirect discards one in-flight word.
        repeat (305) begin next(); drive(0, 1, 8'($urandom), 0); end
        next(); drive(0, 0, 8'h00, 0);
        check("sat_squash", bus.squash_count, 255);

        // Random traffic against the model.
        drive(1, 0, 8'h00, 0);
        next();
        repeat (3000) begin
            next();
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 10,
                  8'($urandom), $urandom_range(0, 99) < 40);
        end
        next(); drive(0, 0, 8'h00, 0);
        next();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
